// File: rtl/bsod_mode_ctrl.sv
// BSODomizer HD control: input synchronisers and debouncers, HDMI mode FSM, lock-gated heartbeat LED.
// Optional build macro BSOD_HB_BLINK_EN: heartbeat blinks 4x faster while in BSOD.
module bsod_mode_ctrl #(
    parameter int          NUM_KEYS    = 4,
    parameter int          DB_CYCLES   = 500000,
    parameter int          HB_BIT      = 26,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                pll_locked,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                sw_bsod,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                hdmi_sw,
    output logic                bsod_active,
    output logic [1:0]          mode,
    output logic                heartbeat
);
    localparam int              NI      = NUM_KEYS + 1;
    localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [NI-1:0]   REL     = {1'b0, {NUM_KEYS{1'b1}}};
    localparam logic [31:0]     TO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        PASS     = 2'd1,
        BSOD     = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NI-1:0]   in_s1;
    logic [NI-1:0]   in_s2;
    logic [NI-1:0]   db_lvl;
    logic [NI-1:0]   db_lvl_d;
    logic [DB_W-1:0] db_cnt [NI];
    logic            lock_s1;
    logic            lock_s2;
    logic            lock_d;
    logic            sw_rise;
    logic            sw_fall;
    logic            enter_req;
    logic            exit_req;
    logic            timeout_hit;
    logic [31:0]     to_cnt;
    logic [HB_BIT:0] hb_cnt;
    logic            hb_src;

    // Keys and switch share one synchroniser vector; the switch sits in the MSB.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            in_s1   <= REL;
            in_s2   <= REL;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            lock_d  <= 1'b0;
        end else begin
            in_s1   <= {sw_bsod, key_n};
            in_s2   <= in_s1;
            lock_s1 <= pll_locked;
            lock_s2 <= lock_s1;
            lock_d  <= lock_s2;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            db_lvl   <= REL;
            db_lvl_d <= REL;
            for (int i = 0; i < NI; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_lvl_d <= db_lvl;
            for (int i = 0; i < NI; i++) begin
                if (in_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= in_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge events are registered so key presses and switch edges reach the FSM with equal latency.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            key_pulse <= '0;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            key_pulse <= db_lvl_d[NUM_KEYS-1:0] & ~db_lvl[NUM_KEYS-1:0];
            sw_rise   <= db_lvl[NUM_KEYS] & ~db_lvl_d[NUM_KEYS];
            sw_fall   <= ~db_lvl[NUM_KEYS] & db_lvl_d[NUM_KEYS];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= LOCKWAIT;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            to_cnt <= (state == BSOD && state_next == BSOD) ? to_cnt + 32'd1 : 32'd0;
        end
    end

    assign timeout_hit = TO_EN && (to_cnt == TO_LAST);
    assign enter_req   = key_pulse[0] | sw_rise;
    assign exit_req    = key_pulse[1] | sw_fall | timeout_hit;

    // Lock loss overrides everything; in BSOD only exit matters, so exit beats enter there.
    always_comb begin
        state_next = state;
        if (!lock_s2) begin
            state_next = LOCKWAIT;
        end else begin
            unique case (state)
                LOCKWAIT: if (lock_d)    state_next = PASS;
                PASS:     if (enter_req) state_next = BSOD;
                BSOD:     if (exit_req)  state_next = PASS;
                default:                 state_next = LOCKWAIT;
            endcase
        end
    end

    assign mode        = state;
    assign hdmi_sw     = (state != BSOD);
    assign bsod_active = (state == BSOD);

`ifdef BSOD_HB_BLINK_EN
    assign hb_src = (state == BSOD) ? hb_cnt[HB_BIT-2] : hb_cnt[HB_BIT];
`else
    assign hb_src = hb_cnt[HB_BIT];
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else begin
            if (lock_s2) begin
                hb_cnt <= hb_cnt + (HB_BIT+1)'(1);
            end
            heartbeat <= hb_src;
        end
    end
endmodule

// File: tb/tb_bsod_mode_ctrl.sv
// Bench for bsod_mode_ctrl: history-based behavioural model checked every cycle, plus directed scenarios.
module tb_bsod_mode_ctrl;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int HB = 3;
    localparam int TO = 20;
    localparam int NI = NK + 1;
    localparam logic [NI-1:0] REL = {1'b0, {NK{1'b1}}};

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          pll_locked = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic          sw_bsod = 1'b0;
    logic [NK-1:0] key_pulse;
    logic          hdmi_sw;
    logic          bsod_active;
    logic [1:0]    mode;
    logic          heartbeat;

    int errors = 0;
    int checks = 0;

    bsod_mode_ctrl #(
        .NUM_KEYS(NK), .DB_CYCLES(DB), .HB_BIT(HB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .resetb(resetb), .pll_locked(pll_locked), .key_n(key_n),
        .sw_bsod(sw_bsod), .key_pulse(key_pulse), .hdmi_sw(hdmi_sw),
        .bsod_active(bsod_active), .mode(mode), .heartbeat(heartbeat)
    );

    initial forever #5 clk = ~clk;

    // Model state: raw inputs reach the logic two edges late; a debounced level flips
    // once the delayed input has disagreed with it for DB consecutive cycles.
    logic [NI-1:0] m_raw_d;
    logic [NI-1:0] m_sync;
    logic [NI-1:0] m_db;
    logic [NI-1:0] m_hist[$];
    logic          m_lock_raw_d;
    logic          m_lock_now;
    logic          m_lock_prev;
    logic [NK-1:0] exp_pulse;
    logic [NK-1:0] m_press_d;
    logic          m_rise_ev;
    logic          m_fall_ev;
    logic          m_rise_d;
    logic          m_fall_d;
    int            exp_mode;
    int            bsod_cycles;
    int            hb_count;
    logic          exp_hb;

    initial begin : model
        logic          enter_ev;
        logic          exit_ev;
        int            nxt;
        logic [NI-1:0] flips;
        forever begin
            @(posedge clk or negedge resetb);
            if (!resetb) begin
                m_raw_d = REL; m_sync = REL; m_db = REL;
                m_hist.delete();
                for (int i = 0; i < DB; i++) m_hist.push_back(REL);
                m_lock_raw_d = 1'b0; m_lock_now = 1'b0; m_lock_prev = 1'b0;
                exp_pulse = '0; m_press_d = '0;
                m_rise_ev = 1'b0; m_fall_ev = 1'b0; m_rise_d = 1'b0; m_fall_d = 1'b0;
                exp_mode = 0; bsod_cycles = 0; hb_count = 0; exp_hb = 1'b0;
            end else begin
                enter_ev = exp_pulse[0] | m_rise_ev;
                exit_ev  = exp_pulse[1] | m_fall_ev | (TO != 0 && bsod_cycles == TO);
                nxt = exp_mode;
                if (!m_lock_now)                    nxt = 0;
                else if (exp_mode == 0 && m_lock_prev) nxt = 1;
                else if (exp_mode == 1 && enter_ev)    nxt = 2;
                else if (exp_mode == 2 && exit_ev)     nxt = 1;
                bsod_cycles = (nxt == 2) ? ((exp_mode == 2) ? bsod_cycles + 1 : 1) : 0;
`ifdef BSOD_HB_BLINK_EN
                exp_hb = (exp_mode == 2) ? hb_count[HB-2] : hb_count[HB];
`else
                exp_hb = hb_count[HB];
`endif
                hb_count = (hb_count + (m_lock_now ? 1 : 0)) % (1 << (HB + 1));
                exp_mode = nxt;

                m_hist.push_back(m_sync);
                void'(m_hist.pop_front());
                flips = '0;
                for (int i = 0; i < NI; i++) begin
                    flips[i] = 1'b1;
                    for (int k = 0; k < m_hist.size(); k++)
                        if (m_hist[k][i] == m_db[i]) flips[i] = 1'b0;
                end
                exp_pulse = m_press_d;
                m_rise_ev = m_rise_d;
                m_fall_ev = m_fall_d;
                m_press_d = flips[NK-1:0] & m_db[NK-1:0];
                m_rise_d  = flips[NK] & ~m_db[NK];
                m_fall_d  = flips[NK] & m_db[NK];
                m_db      = m_db ^ flips;

                m_lock_prev  = m_lock_now;
                m_lock_now   = m_lock_raw_d;
                m_lock_raw_d = pll_locked;
                m_sync       = m_raw_d;
                m_raw_d      = {sw_bsod, key_n};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NK-1:0] keys, input logic sw, input logic lock, input int ncyc);
        key_n = keys;
        sw_bsod = sw;
        pll_locked = lock;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic measurePeriod(output int period);
        int   first;
        logic prev;
        first = -1;
        period = -1;
        @(negedge clk);
        prev = heartbeat;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (heartbeat && !prev) begin
                if (first < 0) first = t;
                else begin
                    period = t - first;
                    break;
                end
            end
            prev = heartbeat;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (resetb) begin
            checkOutput("model_key_pulse", 32'(key_pulse), 32'(exp_pulse));
            checkOutput("model_mode", 32'(mode), exp_mode);
            checkOutput("model_hdmi_sw", 32'(hdmi_sw), (exp_mode == 2) ? 32'd0 : 32'd1);
            checkOutput("model_bsod_active", 32'(bsod_active), (exp_mode == 2) ? 32'd1 : 32'd0);
            checkOutput("model_heartbeat", 32'(heartbeat), 32'(exp_hb));
        end
    end

    initial begin
        $display("[TB] watchdog armed");
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int period;
        applyStimulus('1, 1'b0, 1'b1, 2);
        checkOutput("rst_mode", 32'(mode), 32'd0);
        checkOutput("rst_hdmi_sw", 32'(hdmi_sw), 32'd1);
        checkOutput("rst_bsod_active", 32'(bsod_active), 32'd0);
        checkOutput("rst_heartbeat", 32'(heartbeat), 32'd0);
        checkOutput("rst_key_pulse", 32'(key_pulse), 32'd0);

        resetb = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("lockwait_mode", 32'(mode), (k < 4) ? 32'd0 : 32'd1);
        end
        checkOutput("pass_hdmi_sw", 32'(hdmi_sw), 32'd1);

        // glitch on key 0, then a stable press
        applyStimulus(4'b1110, 1'b0, 1'b1, 2);
        applyStimulus(4'b1111, 1'b0, 1'b1, 2);
        applyStimulus(4'b1110, 1'b0, 1'b1, 6);
        checkOutput("press_no_early_pulse", 32'(key_pulse), 32'd0);
        applyStimulus(4'b1110, 1'b0, 1'b1, 1);
        checkOutput("press_pulse", 32'(key_pulse), 32'h1);
        checkOutput("press_mode_pass", 32'(mode), 32'd1);
        applyStimulus(4'b1110, 1'b0, 1'b1, 1);
        checkOutput("press_mode_bsod", 32'(mode), 32'd2);
        checkOutput("press_hdmi_sw", 32'(hdmi_sw), 32'd0);
        checkOutput("press_pulse_once", 32'(key_pulse), 32'd0);

        // idle in BSOD until timeout
        applyStimulus('1, 1'b0, 1'b1, 19);
        checkOutput("timeout_last_bsod", 32'(mode), 32'd2);
        applyStimulus('1, 1'b0, 1'b1, 1);
        checkOutput("timeout_mode", 32'(mode), 32'd1);
        checkOutput("timeout_hdmi_sw", 32'(hdmi_sw), 32'd1);

        // key 1 and rising switch in the same cycle while in BSOD
        applyStimulus(4'b1110, 1'b0, 1'b1, 8);
        checkOutput("reenter_mode", 32'(mode), 32'd2);
        applyStimulus(4'b1101, 1'b1, 1'b1, 7);
        checkOutput("exit_pulse1", 32'(key_pulse), 32'h2);
        applyStimulus(4'b1101, 1'b1, 1'b1, 1);
        checkOutput("exit_wins_mode", 32'(mode), 32'd1);
        applyStimulus(4'b1101, 1'b1, 1'b1, 2);
        checkOutput("exit_stays_pass", 32'(mode), 32'd1);

        // switch falling in PASS is ignored; rising enters BSOD; then lock loss
        applyStimulus('1, 1'b0, 1'b1, 10);
        checkOutput("fall_in_pass", 32'(mode), 32'd1);
        applyStimulus('1, 1'b1, 1'b1, 8);
        checkOutput("sw_enter_mode", 32'(mode), 32'd2);
        applyStimulus('1, 1'b1, 1'b0, 2);
        checkOutput("unlock_still_bsod", 32'(mode), 32'd2);
        applyStimulus('1, 1'b1, 1'b0, 1);
        checkOutput("unlock_mode", 32'(mode), 32'd0);
        checkOutput("unlock_hdmi_sw", 32'(hdmi_sw), 32'd1);
        applyStimulus('1, 1'b1, 1'b0, 10);

        // relock with the switch already high: PASS, no BSOD
        applyStimulus('1, 1'b1, 1'b1, 3);
        checkOutput("relock_wait", 32'(mode), 32'd0);
        applyStimulus('1, 1'b1, 1'b1, 1);
        checkOutput("relock_pass", 32'(mode), 32'd1);
        applyStimulus('1, 1'b1, 1'b1, 6);
        checkOutput("sw_high_at_lock", 32'(mode), 32'd1);

        measurePeriod(period);
        checkOutput("hb_period_pass", 32'(period), 32'd16);

`ifdef BSOD_HB_BLINK_EN
        applyStimulus('1, 1'b0, 1'b1, 10);
        applyStimulus('1, 1'b1, 1'b1, 8);
        checkOutput("blink_enter", 32'(mode), 32'd2);
        measurePeriod(period);
        checkOutput("hb_period_bsod", 32'(period), 32'd4);
`endif

        // asynchronous reset while in BSOD with a key pulse high
        applyStimulus('1, 1'b0, 1'b1, 25);
        applyStimulus('1, 1'b1, 1'b1, 8);
        checkOutput("pre_reset_mode", 32'(mode), 32'd2);
        applyStimulus(4'b1011, 1'b1, 1'b1, 7);
        checkOutput("pre_reset_pulse", 32'(key_pulse), 32'h4);
        #2 resetb = 1'b0;
        #1;
        checkOutput("async_rst_mode", 32'(mode), 32'd0);
        checkOutput("async_rst_hdmi_sw", 32'(hdmi_sw), 32'd1);
        checkOutput("async_rst_bsod_active", 32'(bsod_active), 32'd0);
        checkOutput("async_rst_key_pulse", 32'(key_pulse), 32'd0);
        checkOutput("async_rst_heartbeat", 32'(heartbeat), 32'd0);
        applyStimulus('1, 1'b0, 1'b1, 2);
        resetb = 1'b1;
        applyStimulus('1, 1'b0, 1'b1, 4);
        checkOutput("after_reset_pass", 32'(mode), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
